// File: rtl/loop_if_pkg.sv
// Shared definitions for the loop index/done control interface.
// Both the controller and the progress reader use the same limit constant.
package loop_if_pkg;

  localparam int unsigned LOOP_LIMIT = 10;
  localparam int unsigned LOOP_IDX_W = 4;
  localparam int unsigned LOOP_CNT_W = 5;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StReport
  } loop_state_e;

  typedef struct packed {
    logic [LOOP_IDX_W-1:0] first;
    logic [LOOP_IDX_W-1:0] last;
    logic [LOOP_CNT_W-1:0] iters;
    logic                  err;
  } loop_rec_t;

endpackage

// File: rtl/loop_progress_reader.sv
// Consumer of the loop index/done interface: tracks one run, checks index
// progression against the limit and emits one summary record per run.
module loop_progress_reader
  import loop_if_pkg::*;
#(
  parameter int unsigned IDX_W = LOOP_IDX_W,
  parameter int unsigned LIMIT = LOOP_LIMIT,
  parameter int unsigned CNT_W = LOOP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sample_en,
  input  logic [IDX_W-1:0] rpt_index,
  input  logic             rpt_done,
  output logic             busy,
  output logic             rep_valid,
  input  logic             rep_ready,
  output logic [IDX_W-1:0] rep_first,
  output logic [IDX_W-1:0] rep_last,
  output logic [CNT_W-1:0] rep_iters,
  output logic             rep_err
);

  typedef struct packed {
    logic [IDX_W-1:0] first;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] iters;
    logic             err;
  } rec_t;

  localparam logic [IDX_W:0]   LimitW = LIMIT[IDX_W:0];
  localparam logic [IDX_W-1:0] IdxOne = 1;
  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  loop_state_e state_q, state_d;
  rec_t        rec_q, rec_d;
  logic        idx_oob;
  logic        idx_next;

  assign idx_oob  = ({1'b0, rpt_index} >= LimitW);
  assign idx_next = (rpt_index == rec_q.last + IdxOne);

  always_comb begin
    state_d = state_q;
    rec_d   = rec_q;
    unique case (state_q)
      StIdle: begin
        if (sample_en) begin
          rec_d.first = rpt_index;
          rec_d.last  = rpt_index;
          if (rpt_done) begin
            state_d     = StReport;
            rec_d.iters = '0;
            rec_d.err   = 1'b0;
          end else begin
            state_d     = StRun;
            rec_d.iters = CntOne;
            rec_d.err   = idx_oob;
          end
        end
      end
      StRun: begin
        if (sample_en) begin
          if (rpt_done) begin
            // The index sampled alongside done is not part of the run.
            state_d = StReport;
          end else begin
            if (rpt_index != rec_q.last) begin
              rec_d.last  = rpt_index;
              rec_d.iters = (rec_q.iters == CntMax) ? rec_q.iters : rec_q.iters + CntOne;
              if (!idx_next) rec_d.err = 1'b1;
            end
            if (idx_oob) rec_d.err = 1'b1;
          end
        end
      end
      StReport: begin
        if (rep_ready) begin
          state_d = StIdle;
          rec_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        rec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      rec_q   <= '0;
    end else begin
      state_q <= state_d;
      rec_q   <= rec_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign rep_valid = (state_q == StReport);
  // Record fields are only visible while the record is offered.
  assign rep_first = rep_valid ? rec_q.first : '0;
  assign rep_last  = rep_valid ? rec_q.last  : '0;
  assign rep_iters = rep_valid ? rec_q.iters : '0;
  assign rep_err   = rep_valid ? rec_q.err   : 1'b0;

endmodule

// File: doc/loop_progress_reader.md
Name: loop_progress_reader

Overview:
- Consumer end of the loop index/done control interface: samples the Report-side signals (index, done) driven by a loop controller.
- Tracks one loop run from first index to completion and checks index progression against the loop limit.
- Emits one summary record per run over a valid/ready handshake to downstream status logic.

Parameters:
- IDX_W, 4, width of the loop index.
- LIMIT, 10, exclusive upper bound on the index; legal running indices are 0..LIMIT-1.
- CNT_W, 5, width of the iteration counter; the counter saturates.

Ports:
- clk  input  1  single clock.
- rst_n  input  1  reset; synchronous and active-low.
- sample_en  input  1  when high, rpt_index/rpt_done are sampled this cycle.
- rpt_index  input  IDX_W  loop index from the controller.
- rpt_done  input  1  loop-complete flag from the controller.
- busy  output  1  high in RUN or REPORT.
- rep_valid  output  1  summary record available.
- rep_ready  input  1  downstream accepts the record.
- rep_first  output  IDX_W  first index seen in the run.
- rep_last  output  IDX_W  last running index seen in the run.
- rep_iters  output  CNT_W  number of distinct index steps counted.
- rep_err  output  1  progression error seen during the run (sticky per run).

Behaviour:
- Reset: a sampled rst_n=0 forces IDLE and clears all outputs and registers to 0. Reset during RUN or REPORT drops the partial or pending record; no rep_valid follows.
- States: IDLE, RUN, REPORT. Only sampled inputs (sample_en=1) cause state changes or register updates. sample_en=0 holds all state.
- IDLE, done=0:
  - Go to RUN; first=last=rpt_index; iters=1.
  - err=1 if rpt_index>=LIMIT.
- IDLE, done=1: empty run.
  - Go to REPORT; first=last=rpt_index; iters=0; err=0.
- RUN, done=0, rpt_index==last: repeat sample; no count, no error.
- RUN, done=0, rpt_index==last+1 (IDX_W-bit add): last=rpt_index; iters++.
- RUN, done=0, any other index: last=rpt_index; iters++; err=1. This covers skips, backward steps and wrap-around.
- RUN, done=0, rpt_index>=LIMIT: err=1, in addition to the rule above.
- RUN, done=1: go to REPORT; first, last and iters are frozen. The index sampled with done=1 is not recorded.
- iters saturates at 2^CNT_W-1. Saturation is not an error.
- REPORT:
  - rep_valid=1; rep_* outputs stable until accepted.
  - Sampled inputs are ignored.
  - On rep_valid&&rep_ready, go to IDLE at the next edge and clear the record registers.
- Latency: done sampled at edge N gives rep_valid=1 in the cycle after edge N. If rep_ready=1 in that cycle, rep_valid is a single-cycle pulse.
- A new run can start only in a sampled cycle after return to IDLE; there is no back-to-back overlap.
- rep_* outputs are registered; they read 0 whenever rep_valid=0.
- busy = (state!=IDLE).

Decomposition:
- Shared package loop_if_pkg:
  - State enum typedef (IDLE/RUN/REPORT).
  - LOOP_LIMIT default constant (10).
  - Record struct typedef {first, last, iters, err}. The controller side reuses the same limit constant.
- No sub-module. The step checker is a few comparisons and stays inline.

Test Plan:
- Start 7: samples (7,0),(8,0),(9,0),(9,1) -> rep_valid the cycle after the done sample; first=7, last=9, iters=3, err=0.
- IDLE sample (10,1) -> empty record: first=10, last=10, iters=0, err=0; busy=1 until accepted.
- Skip: (3,0),(5,0),(6,0),(6,1) -> first=3, last=6, iters=3, err=1.
- Backpressure: complete run 8,9,done with rep_ready=0 for 5 cycles, index toggling meanwhile -> record stable (8,9,2,0); accepted on the first rep_ready=1; IDLE next cycle.
- Reset: rst_n=0 for one edge mid-RUN after (2,0),(3,0) -> all outputs 0, IDLE. Next run (4,0),(4,1) reports first=4, last=4, iters=1.
- Saturation with CNT_W=2: run with indices 0..5 then done -> iters=3, err=0.
